// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults (640x480@60 from 50 MHz) and window-decode helper
// used by the pixel source and the sync/timing stage.
package vga_timing_gen_pkg;

    localparam int unsigned VGA_CLK_DIV  = 2;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_CNT_W    = 10;
    localparam int unsigned VGA_DATA_W   = 30;

    // Evaluated at 32 bits so a window ending exactly at 2**CNT_W cannot wrap.
    function automatic logic in_window(input int unsigned cnt,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Pixel clock-enable divider: one-cycle pix_ce every CLK_DIV clocks, constant 1 when CLK_DIV=1.
module vga_pix_ce_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign pix_ce = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing stage: h/v counters at pixel rate, pixel request decode and the
// registered DAC output stage (data, HSYNC, FSYNC, BLANK, SYNC).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned CNT_W    = VGA_CNT_W,
    parameter int unsigned DATA_W   = VGA_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_req,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              frame_start,
    output logic [DATA_W-1:0] data_to_screen,
    output logic              HSYNC,
    output logic              FSYNC,
    output logic              BLANK,
    output logic              SYNC
);

    localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_ACT_LO = H_SYNC + H_BACK;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BACK;

    if ((CLK_DIV < 1) || (((H_TOTAL - 1) >> CNT_W) != 32'd0) ||
        (((V_TOTAL - 1) >> CNT_W) != 32'd0)) begin : g_bad_params
        $error("vga_timing_gen: CLK_DIV must be >=1 and H_TOTAL/V_TOTAL must fit in CNT_W bits");
    end

    logic             pix_ce;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    logic             h_active;
    logic             v_active;

    vga_pix_ce_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_ce_div (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .pix_ce(pix_ce)
    );

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        h_active    = in_window(32'(h_cnt), H_ACT_LO, H_ACTIVE);
        v_active    = in_window(32'(v_cnt), V_ACT_LO, V_ACTIVE);
        pix_req     = h_active && v_active;
        pix_x       = pix_req ? (h_cnt - CNT_W'(H_ACT_LO)) : '0;
        pix_y       = pix_req ? (v_cnt - CNT_W'(V_ACT_LO)) : '0;
        frame_start = pix_ce && h_last && v_last;
    end

    // Everything to the DAC is loaded together on pix_ce, one slot behind the counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_to_screen <= '0;
            HSYNC          <= 1'b1;
            FSYNC          <= 1'b1;
            BLANK          <= 1'b0;
        end else if (pix_ce) begin
            data_to_screen <= pix_req ? pix_data : '0;
            HSYNC          <= !(32'(h_cnt) < H_SYNC);
            FSYNC          <= !(32'(v_cnt) < V_SYNC);
            BLANK          <= pix_req;
        end
    end

    assign SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, and two reduced timings with
// CLK_DIV=1 and 3) checked every cycle against a slot-arithmetic reference model.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int unsigned C_DIV [NI] = '{2, 1, 3};
    localparam int unsigned C_HS  [NI] = '{96, 4, 3};
    localparam int unsigned C_HB  [NI] = '{48, 3, 2};
    localparam int unsigned C_HA  [NI] = '{640, 8, 6};
    localparam int unsigned C_HF  [NI] = '{16, 2, 1};
    localparam int unsigned C_VS  [NI] = '{2, 2, 1};
    localparam int unsigned C_VB  [NI] = '{33, 2, 1};
    localparam int unsigned C_VA  [NI] = '{480, 5, 4};
    localparam int unsigned C_VF  [NI] = '{10, 1, 2};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [29:0] pix_data       [NI];
    logic        pix_req        [NI];
    logic [9:0]  pix_x          [NI];
    logic [9:0]  pix_y          [NI];
    logic        frame_start    [NI];
    logic [29:0] data_to_screen [NI];
    logic        HSYNC          [NI];
    logic        FSYNC          [NI];
    logic        BLANK          [NI];
    logic        SYNC           [NI];

    always #10 sys_clk = ~sys_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_gen #(
            .CLK_DIV (C_DIV[g]),
            .H_SYNC  (C_HS[g]),
            .H_BACK  (C_HB[g]),
            .H_ACTIVE(C_HA[g]),
            .H_FRONT (C_HF[g]),
            .V_SYNC  (C_VS[g]),
            .V_BACK  (C_VB[g]),
            .V_ACTIVE(C_VA[g]),
            .V_FRONT (C_VF[g]),
            .CNT_W   (10),
            .DATA_W  (30)
        ) u_dut (
            .sys_clk       (sys_clk),
            .sys_rst_n     (sys_rst_n),
            .pix_data      (pix_data[g]),
            .pix_req       (pix_req[g]),
            .pix_x         (pix_x[g]),
            .pix_y         (pix_y[g]),
            .frame_start   (frame_start[g]),
            .data_to_screen(data_to_screen[g]),
            .HSYNC         (HSYNC[g]),
            .FSYNC         (FSYNC[g]),
            .BLANK         (BLANK[g]),
            .SYNC          (SYNC[g])
        );
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: t = sys_clk rising edges since reset release.
    longint      t;
    logic [29:0] exp_data [NI];
    bit          exp_hs   [NI];
    bit          exp_fs   [NI];
    bit          exp_bl   [NI];
    bit          prev_hs  [NI];
    bit          prev_fs  [NI];
    bit          prev_bl  [NI];
    longint      hs_fall  [NI];
    longint      fs_fall  [NI];
    longint      bl_rise  [NI];
    longint      fst_last [NI];

    function automatic longint dv(input int g);  return longint'(C_DIV[g]); endfunction
    function automatic longint ht(input int g);  return longint'(C_HS[g] + C_HB[g] + C_HA[g] + C_HF[g]); endfunction
    function automatic longint vt(input int g);  return longint'(C_VS[g] + C_VB[g] + C_VA[g] + C_VF[g]); endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int g = 0; g < NI; g++) begin
            exp_data[g] = '0;
            exp_hs[g]   = 1'b1;
            exp_fs[g]   = 1'b1;
            exp_bl[g]   = 1'b0;
            prev_hs[g]  = 1'b1;
            prev_fs[g]  = 1'b1;
            prev_bl[g]  = 1'b0;
            hs_fall[g]  = -1;
            fs_fall[g]  = -1;
            bl_rise[g]  = -1;
            fst_last[g] = -1;
        end
    endtask

    // Check all instances at the current t; when adv is set, drive new pix_data,
    // account for the coming clock edge and advance t.
    task automatic step(input bit adv);
        for (int g = 0; g < NI; g++) begin
            longint s, h, v, hlo, vlo;
            bit     ce, req, fst;
            string  p;
            p   = $sformatf("u%0d.", g);
            s   = t / dv(g);
            h   = s % ht(g);
            v   = (s / ht(g)) % vt(g);
            hlo = longint'(C_HS[g] + C_HB[g]);
            vlo = longint'(C_VS[g] + C_VB[g]);
            ce  = (t % dv(g)) == dv(g) - 1;
            req = (h >= hlo) && (h < hlo + longint'(C_HA[g])) &&
                  (v >= vlo) && (v < vlo + longint'(C_VA[g]));
            fst = ce && (h == ht(g) - 1) && (v == vt(g) - 1);

            check({p, "pix_req"},     longint'(pix_req[g]),        longint'(req));
            check({p, "pix_x"},       longint'(pix_x[g]),          req ? h - hlo : 0);
            check({p, "pix_y"},       longint'(pix_y[g]),          req ? v - vlo : 0);
            check({p, "frame_start"}, longint'(frame_start[g]),    longint'(fst));
            check({p, "data"},        longint'(data_to_screen[g]), longint'(exp_data[g]));
            check({p, "HSYNC"},       longint'(HSYNC[g]),          longint'(exp_hs[g]));
            check({p, "FSYNC"},       longint'(FSYNC[g]),          longint'(exp_fs[g]));
            check({p, "BLANK"},       longint'(BLANK[g]),          longint'(exp_bl[g]));
            check({p, "SYNC"},        longint'(SYNC[g]),           0);

            // Period / width measurements on the observed waveforms.
            if (prev_hs[g] && !HSYNC[g]) begin
                if (hs_fall[g] >= 0) check({p, "hs_period"}, t - hs_fall[g], dv(g) * ht(g));
                hs_fall[g] = t;
            end
            if (!prev_hs[g] && HSYNC[g] && hs_fall[g] >= 0)
                check({p, "hs_low"}, t - hs_fall[g], dv(g) * longint'(C_HS[g]));
            if (prev_fs[g] && !FSYNC[g]) begin
                if (fs_fall[g] >= 0) check({p, "fs_period"}, t - fs_fall[g], dv(g) * ht(g) * vt(g));
                fs_fall[g] = t;
            end
            if (!prev_fs[g] && FSYNC[g] && fs_fall[g] >= 0)
                check({p, "fs_low"}, t - fs_fall[g], dv(g) * ht(g) * longint'(C_VS[g]));
            if (!prev_bl[g] && BLANK[g]) bl_rise[g] = t;
            if (prev_bl[g] && !BLANK[g] && bl_rise[g] >= 0)
                check({p, "blank_run"}, t - bl_rise[g], dv(g) * longint'(C_HA[g]));
            if (frame_start[g]) begin
                if (fst_last[g] >= 0) check({p, "frame_period"}, t - fst_last[g], dv(g) * ht(g) * vt(g));
                fst_last[g] = t;
            end
            prev_hs[g] = HSYNC[g];
            prev_fs[g] = FSYNC[g];
            prev_bl[g] = BLANK[g];

            if (adv) begin
                if (g == 1) pix_data[g] = {pix_x[g], pix_y[g], pix_x[g]};
                else        pix_data[g] = 30'($urandom);
                if (ce) begin
                    exp_data[g] = req ? pix_data[g] : '0;
                    exp_hs[g]   = !(h < longint'(C_HS[g]));
                    exp_fs[g]   = !(v < longint'(C_VS[g]));
                    exp_bl[g]   = req;
                end
            end
        end
        if (adv) t++;
    endtask

    task automatic run_steps(input int n);
        repeat (n) begin
            step(1'b1);
            @(negedge sys_clk);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        for (int g = 0; g < NI; g++) pix_data[g] = '0;
        model_reset();
        #100;
        @(negedge sys_clk);
        step(1'b0);
        sys_rst_n = 1'b1;
        run_steps(4001);

        // Default-timing instance now sits at h_cnt=400: reset must act without a clock.
        #3 sys_rst_n = 1'b0;
        #1;
        model_reset();
        step(1'b0);
        repeat (2) @(posedge sys_clk);
        #1 step(1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_steps(8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
